fifo_mem_writer: RTL

FIFO_MEM_WRITER -- requirements
Module: fifo_mem_writer

---
 rtl/fifo_mem_writer.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_mem_writer.sv
// Packs FIFO bytes into 4-lane memory words and writes them with a req/ack handshake.
// Optional macro WORD_PARITY_EN adds a per-lane even-parity output mem_wpar.
module fifo_mem_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk_mem,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_r_en,
  input  logic                    flush,
  output logic                    mem_wr_req,
  input  logic                    mem_wr_ack,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [4*DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]              mem_byte_en,
`ifdef WORD_PARITY_EN
  output logic [3:0]              mem_wpar,
`endif
  output logic                    busy,
  output logic [15:0]             words_written
);

  typedef enum logic {FILL = 1'b0, WRITE = 1'b1} state_t;

  state_t                  state_q;
  logic [1:0]              byte_cnt_q;
  logic [DATA_WIDTH-1:0]   lane_q [4];
  logic [3:0]              byte_en_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             words_q;
  logic                    wr_req_q;

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q    <= FILL;
      byte_cnt_q <= 2'd0;
      byte_en_q  <= 4'd0;
      addr_q     <= '0;
      words_q    <= 16'd0;
      wr_req_q   <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          // A pop always wins over a simultaneous flush.
          if (!fifo_empty) begin
            lane_q[byte_cnt_q]    <= fifo_data;
            byte_en_q[byte_cnt_q] <= 1'b1;
            byte_cnt_q            <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q  <= WRITE;
              wr_req_q <= 1'b1;
            end
          end else if (flush && (byte_cnt_q != 2'd0)) begin
            state_q    <= WRITE;
            byte_cnt_q <= 2'd0;
            wr_req_q   <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_wr_ack) begin
            state_q   <= FILL;
            wr_req_q  <= 1'b0;
            addr_q    <= addr_q + 1'b1;
            words_q   <= words_q + 16'd1;
            byte_en_q <= 4'd0;
            for (int i = 0; i < 4; i++) lane_q[i] <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign fifo_r_en     = !reset && (state_q == FILL) && !fifo_empty;
  assign mem_wr_req    = wr_req_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
  assign mem_byte_en   = byte_en_q;
  assign words_written = words_q;
  assign busy          = (state_q != FILL) || (byte_cnt_q != 2'd0);

`ifdef WORD_PARITY_EN
  function automatic logic lane_parity(input logic [DATA_WIDTH-1:0] d, input logic en);
    return en & (^d);
  endfunction

  // Derived from the held lane registers, so it stays stable with mem_wdata.
  always_comb begin
    mem_wpar = 4'd0;
    for (int i = 0; i < 4; i++) mem_wpar[i] = lane_parity(lane_q[i], byte_en_q[i]);
  end
`endif

endmodule
